serial_paralelo_rx: RTL and testbench
=====================================

// Module: serial_paralelo_rx
// PURPOSE
//  Receive-side serial-to-parallel converter; mirror of the serial-paralelo transmitter.
//  Shifts a 1-bit serial lane MSB-first and hunts for the COM symbol (0xBC) to find byte alignment.
//  Declares lock after COM_LOCK consecutive aligned COMs, then delivers each non-COM byte with a one-cycle valid pulse.
//  Sits between the serial lane and the byte-wide receive logic; all logic runs on the bit clock.
// PARAMETERS
//  COM       8'hBC  alignment/comma symbol; stripped from output once locked
//  IDLE_SYM  8'h7C  idle symbol; delivered as data, flagged on idle_out
//  COM_LOCK  4      consecutive aligned COMs required to lock (range 2..15)
// PORTS
//  clk_1      in   1  bit clock; all state updates on posedge
//  reset      in   1  asynchronous, active-high reset
//  data_in    in   1  serial bit, sampled on posedge clk_1, MSB of each byte first
//  data_out   out  8  last delivered byte
//  valid_out  out  1  one-cycle pulse: data_out holds a new byte
//  idle_out   out  1  high with valid_out when data_out == IDLE_SYM
//  com_det    out  1  one-cycle pulse: an aligned COM completed (ALIGN or LOCKED)
//  active     out  1  high while in LOCKED
// BEHAVIOUR
//  Reset (async, any time): state=HUNT, shift reg sr=0, bit_cnt=0, com_cnt=0;
//   data_out=0, valid_out=0, idle_out=0, com_det=0, active=0. Removal is sampled on posedge clk_1.
//  Every edge: sr <= {sr[6:0], data_in}; nxt = {sr[6:0], data_in} is the byte decision value.
//  valid_out, idle_out, com_det default to 0 each cycle (pulses, never held).
//  States:
//   HUNT:   bit_cnt unused. If nxt==COM -> ALIGN, com_cnt=1, bit_cnt=0, com_det pulses next cycle.
//           Alignment is bit-granular: COM is detectable at any bit offset.
//   ALIGN:  bit_cnt increments 0..7; at bit_cnt==7 (byte boundary), evaluate nxt:
//           nxt==COM and com_cnt+1==COM_LOCK -> LOCKED, active=1, com_det pulse;
//           nxt==COM otherwise -> com_cnt++, com_det pulse, stay;
//           nxt!=COM -> HUNT, com_cnt=0, no pulse, no valid.
//   LOCKED: bit_cnt wraps 7->0. At each boundary: nxt==COM -> com_det pulse, no valid;
//           else data_out<=nxt, valid_out=1, idle_out=(nxt==IDLE_SYM).
//           Lock persists until reset; no loss-of-lock detection in this block.
//  Latency: outputs register on the edge sampling the byte's LSB; pulses are visible for the
//   following clock period. Byte period = 8 clk_1 cycles; valid_out spacing is a multiple of 8.
//  bit_cnt is 3 bits, wraps naturally; com_cnt is 4 bits, never exceeds COM_LOCK.
//  data_out holds its value between valid pulses and through COM bytes.
//  Reset mid-byte in LOCKED: everything returns to reset values immediately; re-lock needs COM_LOCK new COMs.
// TESTING
//  1 Assert reset with random data_in -> all outputs 0 immediately and while reset high.
//  2 After reset, send BC,BC,BC,BC,7C,5A MSB-first -> com_det 4 pulses 8 cycles apart, active rises with
//    4th pulse; valid_out at 7C (idle_out=1) then at 5A (idle_out=0) 8 cycles later; data_out=5A holds.
//  3 Send 3 junk bits 101, then BC x4, 3C -> lock at correct offset, one valid with data_out=3C.
//  4 Send BC,BC,12 then BC x4,A5 -> no valid or active during first group; lock after 2nd group, valid A5.
//  5 Locked stream A5,BC,C3 -> valid A5, com_det only for BC (data_out stays A5), valid C3.
//  6 Assert reset at bit 4 of a byte while LOCKED -> active=0 async; after release BC x3 gives no lock,
//    4th BC locks.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for the COM symbol at any bit offset and locks
// after COM_LOCK aligned COMs. Once locked, each non-COM byte is delivered with a valid pulse.
//
// state  | meaning
// HUNT   | no alignment; checking every bit position for COM
// ALIGN  | COM found; checking byte boundaries for consecutive COMs
// LOCKED | aligned; delivering data bytes, COMs stripped
module serial_paralelo_rx #(
    parameter logic [7:0] COM      = 8'hBC,
    parameter logic [7:0] IDLE_SYM = 8'h7C,
    parameter int         COM_LOCK = 4
) (
    input  logic       clk_1,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       idle_out,
    output logic       com_det,
    output logic       active
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] ALIGN  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [3:0] LOCK_N = COM_LOCK[3:0];

    logic [1:0] state;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic [7:0] nxt;
    logic       nxt_is_com;

    // Byte decision value includes the bit being sampled on this edge
    assign nxt        = {sr[6:0], data_in};
    assign nxt_is_com = (nxt == COM);

    always_ff @(posedge clk_1 or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            com_cnt   <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            idle_out  <= 1'b0;
            com_det   <= 1'b0;
            active    <= 1'b0;
        end else begin
            sr        <= nxt;
            valid_out <= 1'b0;
            idle_out  <= 1'b0;
            com_det   <= 1'b0;
            case (state)
                HUNT: begin
                    if (nxt_is_com) begin
                        state   <= ALIGN;
                        com_cnt <= 4'd1;
                        bit_cnt <= 3'd0;
                        com_det <= 1'b1;
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (nxt_is_com) begin
                            com_cnt <= com_cnt + 4'd1;
                            com_det <= 1'b1;
                            if (com_cnt + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                active <= 1'b1;
                            end
                        end else begin
                            state   <= HUNT;
                            com_cnt <= 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (nxt_is_com) begin
                            com_det <= 1'b1;
                        end else begin
                            data_out  <= nxt;
                            valid_out <= 1'b1;
                            idle_out  <= (nxt == IDLE_SYM);
                        end
                    end
                end
                default: begin
                    state   <= HUNT;
                    com_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: shifts bytes MSB-first and checks pulses,
// lock timing and delivered data against hand-computed values.
module tb_serial_paralelo_rx;

    logic       clk_1 = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       idle_out;
    logic       com_det;
    logic       active;

    int   vectors     = 0;
    int   miscompares = 0;
    int   nv;
    int   nc;
    logic fv;
    logic fc;

    serial_paralelo_rx dut (
        .clk_1    (clk_1),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .idle_out (idle_out),
        .com_det  (com_det),
        .active   (active)
    );

    always #5 clk_1 = ~clk_1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift the low n bits of b, MSB first; sample 1 time unit after each edge
    task automatic send_bits(input logic [7:0] b, input int n);
        nv = 0;
        nc = 0;
        for (int i = n - 1; i >= 0; i--) begin
            data_in = b[i];
            @(posedge clk_1);
            #1;
            nv += int'(valid_out);
            nc += int'(com_det);
        end
        fv = valid_out;
        fc = com_det;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b, input int ev, input int ec,
                               input logic eact, input logic [7:0] edata, input logic eidle);
        send_bits(b, 8);
        chk({tag, ".valid_cnt"}, nv, ev);
        chk({tag, ".com_cnt"}, nc, ec);
        chk({tag, ".valid_at_lsb"}, {31'd0, fv}, ev);
        chk({tag, ".com_at_lsb"}, {31'd0, fc}, ec);
        chk({tag, ".active"}, {31'd0, active}, {31'd0, eact});
        chk({tag, ".data_out"}, {24'd0, data_out}, {24'd0, edata});
        chk({tag, ".idle_out"}, {31'd0, idle_out}, {31'd0, eidle});
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {20'd0, data_out, valid_out, idle_out, com_det, active}, 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        chk_all_zero({tag, ".async"});
        @(posedge clk_1);
        #1;
        chk_all_zero({tag, ".held"});
        reset   = 1'b0;
        data_in = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;

        // 1: reset held with random serial data
        for (int i = 0; i < 4; i++) begin
            data_in = 1'($urandom);
            @(posedge clk_1);
            #1;
            chk_all_zero($sformatf("t1.reset_cyc%0d", i));
        end
        reset   = 1'b0;
        data_in = 1'b0;

        // 2: clean lock, idle then data
        expect_byte("t2.bc1", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t2.bc2", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t2.bc3", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t2.bc4", 8'hBC, 0, 1, 1'b1, 8'h00, 1'b0);
        expect_byte("t2.7c",  8'h7C, 1, 0, 1'b1, 8'h7C, 1'b1);
        expect_byte("t2.5a",  8'h5A, 1, 0, 1'b1, 8'h5A, 1'b0);
        send_bits(8'h00, 3);
        chk("t2.hold_valid", nv, 0);
        chk("t2.hold_data", {24'd0, data_out}, 32'h5A);

        // 3: lock found at a 3-bit offset
        pulse_reset("t3.rst");
        send_bits(8'b0000_0101, 3);
        chk("t3.junk_com", nc, 0);
        chk("t3.junk_valid", nv, 0);
        expect_byte("t3.bc1", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t3.bc2", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t3.bc3", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t3.bc4", 8'hBC, 0, 1, 1'b1, 8'h00, 1'b0);
        expect_byte("t3.3c",  8'h3C, 1, 0, 1'b1, 8'h3C, 1'b0);

        // 5: COM stripped from a locked stream
        expect_byte("t5.a5", 8'hA5, 1, 0, 1'b1, 8'hA5, 1'b0);
        expect_byte("t5.bc", 8'hBC, 0, 1, 1'b1, 8'hA5, 1'b0);
        expect_byte("t5.c3", 8'hC3, 1, 0, 1'b1, 8'hC3, 1'b0);

        // 6: reset mid-byte while locked, re-lock needs a full COM run
        send_bits(8'h96, 4);
        chk("t6.midbyte_active", {31'd0, active}, 32'd1);
        pulse_reset("t6.rst");
        expect_byte("t6.bc1", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t6.bc2", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t6.bc3", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t6.bc4", 8'hBC, 0, 1, 1'b1, 8'h00, 1'b0);
        expect_byte("t6.7c",  8'h7C, 1, 0, 1'b1, 8'h7C, 1'b1);

        // 4: broken COM run drops back to hunting
        pulse_reset("t4.rst");
        expect_byte("t4.bc1", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t4.bc2", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t4.12",  8'h12, 0, 0, 1'b0, 8'h00, 1'b0);
        expect_byte("t4.bc3", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t4.bc4", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t4.bc5", 8'hBC, 0, 1, 1'b0, 8'h00, 1'b0);
        expect_byte("t4.bc6", 8'hBC, 0, 1, 1'b1, 8'h00, 1'b0);
        expect_byte("t4.a5",  8'hA5, 1, 0, 1'b1, 8'hA5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
